pos_cache_reader: RTL and testbench

- Read-side sequencer for one position cache (cell memory, double-buffered).
- On start: reads address 0 (particle count N), then streams particles at addresses 1..N to the force pipeline over a valid/ready interface.
- Drives the cache's read address and read enable, absorbs the cache's 1-cycle read latency, and handles downstream backpressure with a 2-entry output buffer.
- Aborts cleanly if a motion update begins mid-pass.

---
 rtl/pos_cache_reader_if.sv | 24 ++
 rtl/pos_cache_reader.sv | 211 +++++++++++++++++++++
 tb/tb_pos_cache_reader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pos_cache_reader_if.sv
// Cache read port plus particle output stream of pos_cache_reader.
// master = reader side, slave = cache/consumer side.
interface pos_cache_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   out_read_address;
  logic                    out_rden;
  logic [3*DATA_WIDTH-1:0] in_particle_info;
  logic [3*DATA_WIDTH-1:0] out_pos;
  logic [ADDR_WIDTH-1:0]   out_pos_index;
  logic                    out_pos_valid;
  logic                    in_ready;

  modport master (
    output out_read_address, out_rden, out_pos, out_pos_index, out_pos_valid,
    input  in_particle_info, in_ready
  );

  modport slave (
    input  out_read_address, out_rden, out_pos, out_pos_index, out_pos_valid,
    output in_particle_info, in_ready
  );
endinterface

// File: rtl/pos_cache_reader.sv
// Read-side sequencer for one position cache: reads N at address 0, streams particles 1..N.
// Optional stall-cycle counter output enabled by POS_READER_STALL_CNT_EN.
module pos_cache_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  motion_update_enable,
  pos_cache_reader_if.master    bus,
  output logic [ADDR_WIDTH-1:0] out_particle_count,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_abort,
  output logic                  out_count_err
`ifdef POS_READER_STALL_CNT_EN
  ,
  output logic [15:0]           out_stall_cycles
`endif
);

  localparam int PW = 3 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_CNT   = 3'd1;
  localparam logic [2:0] S_WAIT_CNT = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  err_q, err_d;
  logic                  abort_q, abort_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            occ_q, occ_d;
  logic [PW-1:0]         s0_data_q, s0_data_d, s1_data_q, s1_data_d;
  logic [ADDR_WIDTH-1:0] s0_idx_q, s0_idx_d, s1_idx_q, s1_idx_d;

  logic                  active, abort_now, launch, push, pop, issue;
  logic [2:0]            load;
  logic [ADDR_WIDTH-1:0] raw_cnt;

  assign active    = (state_q == S_RD_CNT) || (state_q == S_WAIT_CNT) ||
                     (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign abort_now = active && motion_update_enable;
  assign launch    = (state_q == S_IDLE) && (start || pending_q) && !motion_update_enable;
  assign push      = rd_pend_q;
  assign pop       = (occ_q != 2'd0) && bus.in_ready;
  // A beat leaving this cycle frees its slot, which keeps throughput at one per cycle.
  assign load      = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = (state_q == S_STREAM) && (load < 3'd2);
  assign raw_cnt   = bus.in_particle_info[ADDR_WIDTH-1:0];

  assign bus.out_rden         = (state_q == S_RD_CNT) || issue;
  assign bus.out_read_address = issue ? next_addr_q : '0;
  assign bus.out_pos_valid    = (occ_q != 2'd0);
  assign bus.out_pos          = s0_data_q;
  assign bus.out_pos_index    = s0_idx_q;
  assign out_particle_count   = count_q;
  assign out_busy             = (state_q != S_IDLE);
  assign out_done             = (state_q == S_DONE);
  assign out_abort            = abort_q;
  assign out_count_err        = err_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    err_d       = err_q;
    abort_d     = 1'b0;
    rd_pend_d   = issue;
    rd_addr_d   = issue ? next_addr_q : rd_addr_q;
    occ_d       = occ_q;
    s0_data_d   = s0_data_q;
    s0_idx_d    = s0_idx_q;
    s1_data_d   = s1_data_q;
    s1_idx_d    = s1_idx_q;

    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          s0_data_d = bus.in_particle_info;
          s0_idx_d  = rd_addr_q;
        end else begin
          s1_data_d = bus.in_particle_info;
          s1_idx_d  = rd_addr_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        s0_data_d = s1_data_q;
        s0_idx_d  = s1_idx_q;
        occ_d     = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          s0_data_d = bus.in_particle_info;
          s0_idx_d  = rd_addr_q;
        end else begin
          s0_data_d = s1_data_q;
          s0_idx_d  = s1_idx_q;
          s1_data_d = bus.in_particle_info;
          s1_idx_d  = rd_addr_q;
        end
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d   = S_RD_CNT;
          pending_d = 1'b0;
          err_d     = 1'b0;
        end else if (start) begin
          pending_d = 1'b1;
        end
      end
      S_RD_CNT: state_d = S_WAIT_CNT;
      S_WAIT_CNT: begin
        if (raw_cnt > MAX_N) begin
          count_d = MAX_N;
          err_d   = 1'b1;
        end else begin
          count_d = raw_cnt;
        end
        next_addr_d = ADDR_WIDTH'(1);
        state_d     = (raw_cnt == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (issue) begin
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
          if (next_addr_q == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if ((occ_d == 2'd0) && !rd_pend_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_now) begin
      state_d   = S_IDLE;
      abort_d   = 1'b1;
      occ_d     = 2'd0;
      rd_pend_d = 1'b0;
      if (start) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      next_addr_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      occ_q       <= 2'd0;
      s0_data_q   <= '0;
      s0_idx_q    <= '0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      occ_q       <= occ_d;
      s0_data_q   <= s0_data_d;
      s0_idx_q    <= s0_idx_d;
      s1_data_q   <= s1_data_d;
      s1_idx_q    <= s1_idx_d;
    end
  end

`ifdef POS_READER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (launch) begin
      stall_d = '0;
    end else if ((state_q != S_IDLE) && (occ_q != 2'd0) && !bus.in_ready &&
                 (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign out_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pos_cache_reader.sv
// Randomized self-checking bench for pos_cache_reader against a cache/consumer model.
`timescale 1ns/1ps
module tb_pos_cache_reader;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int PW = 3 * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic mue = 1'b0;
  logic [AW-1:0] count;
  logic busy, done, abort, cerr;
`ifdef POS_READER_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  pos_cache_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pos_cache_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .motion_update_enable (mue),
    .bus                  (bus.master),
    .out_particle_count   (count),
    .out_busy             (busy),
    .out_done             (done),
    .out_abort            (abort),
    .out_count_err        (cerr)
`ifdef POS_READER_STALL_CNT_EN
    ,
    .out_stall_cycles     (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cache model: 1-cycle read latency
  logic [PW-1:0] mem [256];
  always @(posedge clk) if (bus.out_rden) bus.in_particle_info <= mem[bus.out_read_address];

  // consumer: 0 = always ready, 1 = pattern 1,0,0, 2 = random
  int ready_mode = 0;
  int rdy_phase = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.in_ready = 1'b1;
      1:       begin bus.in_ready = (rdy_phase % 3 == 0); rdy_phase++; end
      default: bus.in_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // observation of the stream
  logic [AW-1:0] obs_idx[$];
  logic [PW-1:0] obs_data[$];
  int cyc = 0, first_cyc, last_cyc, done_cnt, done_cyc, abort_cnt;
  int rden_cnt, rd_issued, max_out, stall_tb;
  logic prev_stall = 1'b0;
  logic [PW-1:0] prev_pos;
  logic [AW-1:0] prev_idx;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (prev_stall && bus.out_pos_valid && busy) begin
        check("hold_pos", bus.out_pos, prev_pos);
        check("hold_idx", bus.out_pos_index, prev_idx);
      end
      prev_stall = bus.out_pos_valid && !bus.in_ready && busy;
      prev_pos   = bus.out_pos;
      prev_idx   = bus.out_pos_index;
      if (bus.out_pos_valid && bus.in_ready) begin
        obs_idx.push_back(bus.out_pos_index);
        obs_data.push_back(bus.out_pos);
        if (obs_idx.size() == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (abort) abort_cnt++;
      if (bus.out_rden) begin
        rden_cnt++;
        if (bus.out_read_address != '0) rd_issued++;
      end
      if (busy && bus.out_pos_valid && !bus.in_ready) stall_tb++;
      if (rd_issued - obs_idx.size() > max_out) max_out = rd_issued - obs_idx.size();
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_obs();
    obs_idx.delete();
    obs_data.delete();
    first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1; abort_cnt = 0;
    rden_cnt = 0; rd_issued = 0; max_out = 0; stall_tb = 0;
  endtask

  task automatic load_cache(input int n_raw);
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0][AW-1:0] = n_raw[AW-1:0];
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_to_idle(input int budget);
    bit seen_busy = 0;
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin seen_busy = 1; break; end
      @(negedge clk);
    end
    if (seen_busy) begin
      for (int i = 0; i < budget; i++) begin
        @(negedge clk);
        if (!busy) begin ok = 1; break; end
      end
    end
    check("pass_completes_in_budget", ok, 1'b1);
  endtask

  task automatic wait_beats(input int k, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_idx.size() >= k) begin ok = 1; break; end
    end
    check("beats_arrive_in_budget", ok, 1'b1);
  endtask

  // reference: a normal pass yields particles 1..min(N,PN) from the cache, in order
  task automatic verify_pass(input int n_raw);
    int n;
    n = (n_raw > PN) ? PN : n_raw;
    check("beat_count", obs_idx.size(), n);
    for (int i = 0; i < obs_idx.size() && i < n; i++) begin
      check("beat_idx", obs_idx[i], i + 1);
      check("beat_data", obs_data[i], mem[i+1]);
    end
    check("particle_count", count, n);
    check("count_err", cerr, (n_raw > PN));
    check("done_pulses", done_cnt, 1);
    check("abort_pulses", abort_cnt, 0);
    check("outstanding_le_2", (max_out <= 2), 1'b1);
    check("busy_after", busy, 1'b0);
    if (n > 0) check("done_after_last_beat", done_cyc, last_cyc + 1);
`ifdef POS_READER_STALL_CNT_EN
    check("stall_cycles", stall_cycles, stall_tb);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, nr;
    bus.in_ready = 1'b1;
    bus.in_particle_info = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_obs();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", bus.out_pos_valid, 1'b0);
    check("rst_rden", bus.out_rden, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_abort", abort, 1'b0);
    check("rst_count", count, 0);
    check("rst_cerr", cerr, 1'b0);
    rst = 1'b1;

    // N=5, always ready: latency and full throughput
    ready_mode = 0;
    load_cache(5);
    clear_obs();
    pulse_start();
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_pos_valid) break;
      @(posedge clk);
      lat++;
    end
    check("first_valid_latency", lat, 4);
    run_to_idle(100);
    verify_pass(5);
    check("throughput", last_cyc - first_cyc, 4);

    // N=0: only the count read
    load_cache(0);
    clear_obs();
    pulse_start();
    run_to_idle(50);
    verify_pass(0);
    check("n0_rden_cycles", rden_cnt, 1);
    check("n0_data_reads", rd_issued, 0);

    // N=8 with ready pattern 1,0,0
    ready_mode = 1;
    rdy_phase = 0;
    load_cache(8);
    clear_obs();
    pulse_start();
    run_to_idle(200);
    verify_pass(8);

    // count above PARTICLE_NUM is clamped
    ready_mode = 0;
    load_cache(250);
    clear_obs();
    pulse_start();
    run_to_idle(600);
    verify_pass(250);
    if (obs_idx.size() > 0) check("clamp_last_idx", obs_idx[obs_idx.size()-1], PN);

    // random counts, random backpressure
    ready_mode = 2;
    for (int t = 0; t < 4; t++) begin
      nr = $urandom_range(1, 40);
      load_cache(nr);
      clear_obs();
      pulse_start();
      run_to_idle(400);
      verify_pass(nr);
    end

    // abort mid-pass, with start in the abort cycle
    ready_mode = 0;
    load_cache(10);
    clear_obs();
    pulse_start();
    wait_beats(3, 50);
    @(posedge clk); #1 mue = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("abort_pulse", abort, 1'b1);
    check("abort_valid", bus.out_pos_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    k = obs_idx.size();
    check("abort_prefix_len", (k >= 3 && k < 10), 1'b1);
    for (int i = 0; i < k; i++) check("abort_prefix_idx", obs_idx[i], i + 1);
    repeat (3) @(posedge clk);
    #1;
    check("pending_waits", busy, 1'b0);
    check("abort_no_done", done_cnt, 0);
    check("abort_pulse_count", abort_cnt, 1);
    clear_obs();
    mue = 1'b0;
    run_to_idle(100);
    verify_pass(10);

    // asynchronous reset mid-stream
    load_cache(20);
    clear_obs();
    pulse_start();
    wait_beats(5, 50);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", bus.out_pos_valid, 1'b0);
    check("arst_rden", bus.out_rden, 1'b0);
    check("arst_addr", bus.out_read_address, 0);
    check("arst_pos", bus.out_pos, 0);
    check("arst_idx", bus.out_pos_index, 0);
    check("arst_count", count, 0);
    @(negedge clk); #2 rst = 1'b1;
    ready_mode = 2;
    load_cache(6);
    clear_obs();
    pulse_start();
    run_to_idle(100);
    verify_pass(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
